// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: source-FIFO, destination-FIFO and status signals of the VC arbiter
interface vc_arbiter_if #(
   parameter int DATA_WIDTH = 6
);
   logic                  enable;
   logic [DATA_WIDTH-1:0] vc0_data;
   logic                  vc0_empty;
   logic [DATA_WIDTH-1:0] vc1_data;
   logic                  vc1_empty;
   logic                  d0_almost_full;
   logic                  d1_almost_full;
   logic                  pop_vc0;
   logic                  pop_vc1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  push_d0;
   logic                  push_d1;
   logic                  idle;
   modport master (
      output enable, vc0_data, vc0_empty, vc1_data, vc1_empty, d0_almost_full, d1_almost_full,
      input  pop_vc0, pop_vc1, data_out, push_d0, push_d1, idle
   );
   modport slave (
      input  enable, vc0_data, vc0_empty, vc1_data, vc1_empty, d0_almost_full, d1_almost_full,
      output pop_vc0, pop_vc1, data_out, push_d0, push_d1, idle
   );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: strict-priority VC0/VC1 arbiter with VC1 starvation guard, one word per cycle to D0/D1
module vc_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int MAX_STARVE = 3
) (
   input logic         clk,
   input logic         reset,
   vc_arbiter_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam int CW = $clog2(MAX_STARVE + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_STARVE);
   state_t                state_q, state_d;
   logic [CW-1:0]         starv_q, starv_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  push_d0_q, push_d0_d;
   logic                  push_d1_q, push_d1_d;
   logic                  idle_q, idle_d;
   logic                  e0, e1, grant_ok, g0, g1, any_word;
   // eligibility, grant selection, next state and next registered outputs
   always_comb begin
      e0         = !bus.vc0_empty && !(bus.vc0_data[DATA_WIDTH-2] ? bus.d1_almost_full : bus.d0_almost_full);
      e1         = !bus.vc1_empty && !(bus.vc1_data[DATA_WIDTH-2] ? bus.d1_almost_full : bus.d0_almost_full);
      grant_ok   = (state_q == RUN) && bus.enable;
      g1         = grant_ok && e1 && (!e0 || starv_q == MAX_C);
      g0         = grant_ok && e0 && !g1;
      starv_d    = (g1 || !e1) ? '0 : g0 ? starv_q + 1'b1 : starv_q;
      any_word   = !bus.vc0_empty || !bus.vc1_empty;
      state_d    = (state_q == IDLE) ? ((bus.enable && any_word) ? RUN : IDLE)
                                     : ((!bus.enable || !any_word) ? IDLE : RUN);
      data_out_d = g1 ? bus.vc1_data : g0 ? bus.vc0_data : '0;
      push_d0_d  = (g0 || g1) && !data_out_d[DATA_WIDTH-2];
      push_d1_d  = (g0 || g1) && data_out_d[DATA_WIDTH-2];
      idle_d     = (state_d == IDLE) && !push_d0_d && !push_d1_d;
   end
   // state, starvation counter and output stage registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         starv_q    <= '0;
         data_out_q <= '0;
         push_d0_q  <= 1'b0;
         push_d1_q  <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         starv_q    <= starv_d;
         data_out_q <= data_out_d;
         push_d0_q  <= push_d0_d;
         push_d1_q  <= push_d1_d;
         idle_q     <= idle_d;
      end
   end
   assign bus.pop_vc0  = g0;
   assign bus.pop_vc1  = g1;
   assign bus.data_out = data_out_q;
   assign bus.push_d0  = push_d0_q;
   assign bus.push_d1  = push_d1_q;
   assign bus.idle     = idle_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed and random checks of vc_arbiter against a behavioural model
module tb_vc_arbiter;
   localparam int MAXS = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;
   vc_arbiter_if #(.DATA_WIDTH(6)) bus ();
   vc_arbiter #(.DATA_WIDTH(6), .MAX_STARVE(MAXS)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   bit         m_run;
   int         m_streak;
   logic [5:0] m_data;
   bit         m_p0, m_p1, m_idle;
   int         cur_g;
   bit         cur_e1;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_run = 0; m_streak = 0; m_data = '0; m_p0 = 0; m_p1 = 0; m_idle = 1;
   endtask
   task automatic drv(input bit en, input logic [5:0] h0, input bit m0, input logic [5:0] h1,
                      input bit m1, input bit a0, input bit a1);
      bus.enable = en; bus.vc0_data = h0; bus.vc0_empty = m0; bus.vc1_data = h1;
      bus.vc1_empty = m1; bus.d0_almost_full = a0; bus.d1_almost_full = a1;
   endtask
   task automatic check_cycle();
      bit el0, el1;
      #2;
      el0 = !bus.vc0_empty && !(bus.vc0_data[4] ? bus.d1_almost_full : bus.d0_almost_full);
      el1 = !bus.vc1_empty && !(bus.vc1_data[4] ? bus.d1_almost_full : bus.d0_almost_full);
      if (!reset || !m_run || !bus.enable) cur_g = 0;
      else if (el0 && el1) cur_g = (m_streak == MAXS) ? 2 : 1;
      else cur_g = el0 ? 1 : el1 ? 2 : 0;
      cur_e1 = el1;
      chk("pop_vc0", 8'(bus.pop_vc0), 8'(cur_g == 1));
      chk("pop_vc1", 8'(bus.pop_vc1), 8'(cur_g == 2));
      chk("data_out", 8'(bus.data_out), 8'(m_data));
      chk("push_d0", 8'(bus.push_d0), 8'(m_p0));
      chk("push_d1", 8'(bus.push_d1), 8'(m_p1));
      chk("idle", 8'(bus.idle), 8'(m_idle));
   endtask
   task automatic advance();
      bit n_run, np0, np1;
      int n_streak;
      logic [5:0] w;
      n_run    = bus.enable && (!bus.vc0_empty || !bus.vc1_empty);
      n_streak = (cur_g == 2 || !cur_e1) ? 0 : (cur_g == 1) ? m_streak + 1 : m_streak;
      w        = (cur_g == 1) ? bus.vc0_data : (cur_g == 2) ? bus.vc1_data : 6'h00;
      np0      = cur_g != 0 && !w[4];
      np1      = cur_g != 0 && w[4];
      @(posedge clk);
      #1;
      if (!reset) model_reset();
      else begin
         m_run = n_run; m_streak = n_streak; m_data = w; m_p0 = np0; m_p1 = np1;
         m_idle = !n_run && !np0 && !np1;
      end
   endtask
   initial begin
      drv(0, 6'h00, 1, 6'h00, 1, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_cycle();
      reset = 1'b1;
      advance();
      // single VC1 word: pop one cycle after it appears, push the cycle after that
      drv(1, 6'h00, 1, 6'h30, 0, 0, 0);
      check_cycle();
      chk("t2_idle_nopop", 8'(bus.pop_vc1), 8'd0);
      advance();
      check_cycle();
      chk("t2_pop", 8'(bus.pop_vc1), 8'd1);
      advance();
      drv(1, 6'h00, 1, 6'h00, 1, 0, 0);
      check_cycle();
      chk("t2_data", 8'(bus.data_out), 8'h30);
      chk("t2_push_d1", 8'(bus.push_d1), 8'd1);
      advance();
      check_cycle();
      advance();
      // both full, all to D0: VC0,VC0,VC0,VC1 repeating
      drv(1, 6'h05, 0, 6'h2A, 0, 0, 0);
      check_cycle();
      advance();
      for (int i = 0; i < 12; i++) begin
         check_cycle();
         chk("t3_vc1", 8'(bus.pop_vc1), 8'(i % 4 == 3));
         chk("t3_vc0", 8'(bus.pop_vc0), 8'(i % 4 != 3));
         advance();
      end
      // VC0 blocked by D1 almost-full, VC1 goes to D0
      drv(1, 6'h10, 0, 6'h20, 0, 0, 1);
      check_cycle();
      chk("t4_pop1", 8'(bus.pop_vc1), 8'd1);
      chk("t4_pop0", 8'(bus.pop_vc0), 8'd0);
      advance();
      check_cycle();
      chk("t4_data", 8'(bus.data_out), 8'h20);
      chk("t4_push_d0", 8'(bus.push_d0), 8'd1);
      advance();
      // both destinations almost full: RUN held without pops
      drv(1, 6'h05, 0, 6'h30, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         check_cycle();
         chk("t5_nopop", 8'({bus.pop_vc0, bus.pop_vc1}), 8'd0);
         advance();
      end
      check_cycle();
      chk("t5_idle", 8'(bus.idle), 8'd0);
      advance();
      // enable dropped after two grants
      drv(1, 6'h05, 0, 6'h2A, 0, 0, 0);
      check_cycle();
      chk("t6_g1", 8'(bus.pop_vc0), 8'd1);
      advance();
      check_cycle();
      chk("t6_g2", 8'(bus.pop_vc0), 8'd1);
      advance();
      drv(0, 6'h05, 0, 6'h2A, 0, 0, 0);
      check_cycle();
      chk("t6_nopop", 8'({bus.pop_vc0, bus.pop_vc1}), 8'd0);
      chk("t6_push", 8'(bus.push_d0), 8'd1);
      chk("t6_notidle", 8'(bus.idle), 8'd0);
      advance();
      check_cycle();
      chk("t6_idle", 8'(bus.idle), 8'd1);
      advance();
      // reset asserted mid-transfer
      drv(1, 6'h05, 0, 6'h3A, 0, 0, 0);
      check_cycle();
      advance();
      check_cycle();
      advance();
      reset = 1'b0;
      #1;
      model_reset();
      check_cycle();
      chk("t1_data", 8'(bus.data_out), 8'd0);
      chk("t1_idle", 8'(bus.idle), 8'd1);
      chk("t1_nopop", 8'({bus.pop_vc0, bus.pop_vc1}), 8'd0);
      advance();
      check_cycle();
      reset = 1'b1;
      advance();
      // random traffic with occasional asynchronous reset pulses
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 7) != 0, 6'($urandom_range(0, 63)), $urandom_range(0, 2) == 0,
             6'($urandom_range(0, 63)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_cycle();
            advance();
            reset = 1'b1;
         end else begin
            check_cycle();
            advance();
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
